mux_nb_pipe: RTL and testbench

//   Parametrised NUM_IN:1, WIDTH-bit selector with a registered output and a valid/ready handshake.

---
 rtl/mux_nb_pipe_if.sv | 27 ++
 rtl/mux_nb_pipe.sv | 146 ++++++++++++++
 tb/tb_mux_nb_pipe.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mux_nb_pipe_if.sv
// Handshake bundle for mux_nb_pipe: upstream lanes/select with valid/ready,
// registered downstream beat with valid/ready, and the output beat counter.
interface mux_nb_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             beat_cnt;

  modport master (
    output sel, data_in, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, beat_cnt
  );

  modport slave (
    input  sel, data_in, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, beat_cnt
  );
endinterface

// File: rtl/mux_nb_pipe.sv
// NUM_IN:1 WIDTH-bit selector with registered output and a 2-entry skid buffer.
// Optional MUX_SEL_CHECK_EN adds a sticky sel_err flag and drops out-of-range beats.
module mux_nb_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_nb_pipe_if.slave  bus
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic          sel_err
`endif
);

  localparam int SEL_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               in_ready_q;
  logic [15:0]        beat_cnt_q, beat_cnt_d;

  logic               accept;
  logic               keep;
  logic               out_fire;
  logic [WIDTH-1:0]   lane_in;

  // Out-of-range selects fall through to lane 0.
  function automatic logic [WIDTH-1:0] select_lane(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH-1:0] lane;
    lane = d[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (int'(s) == k) lane = d[k*WIDTH +: WIDTH];
    end
    return lane;
  endfunction

  assign accept   = bus.in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && bus.out_ready;
  assign lane_in  = select_lane(bus.data_in, bus.sel);

`ifdef MUX_SEL_CHECK_EN
  logic sel_ok;
  logic sel_err_q, sel_err_d;

  assign sel_ok    = (int'(bus.sel) < NUM_IN);
  assign keep      = accept && sel_ok;
  assign sel_err_d = sel_err_q || (accept && !sel_ok);
  assign sel_err   = sel_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end
`else
  assign keep = accept;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_sel_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Skid contents are qualified by state, so they need no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_sel_q  <= skid_sel_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (keep) state_d = ONE;
      ONE: begin
        if (keep && !bus.out_ready)      state_d = FULL;
        else if (!keep && bus.out_ready) state_d = EMPTY;
      end
      FULL:    if (bus.out_ready) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Storage steering: a beat arriving while main drains goes straight to main.
  always_comb begin
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    beat_cnt_d  = out_fire ? beat_cnt_q + 16'd1 : beat_cnt_q;
    case (state_q)
      EMPTY: begin
        if (keep) begin
          main_data_d = lane_in;
          main_sel_d  = bus.sel;
        end
      end
      ONE: begin
        if (keep && bus.out_ready) begin
          main_data_d = lane_in;
          main_sel_d  = bus.sel;
        end else if (keep) begin
          skid_data_d = lane_in;
          skid_sel_d  = bus.sel;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = (state_q != EMPTY);
    bus.out_data  = main_data_q;
    bus.out_sel   = main_sel_q;
    bus.beat_cnt  = beat_cnt_q;
  end

endmodule

// File: tb/tb_mux_nb_pipe.sv
// Directed bench for mux_nb_pipe: a 4-lane instance for the handshake paths
// and a 3-lane instance for out-of-range select handling.
module tb_mux_nb_pipe;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mux_nb_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus ();
  mux_nb_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

`ifdef MUX_SEL_CHECK_EN
  logic sel_err4;
  logic sel_err3;
`endif

  mux_nb_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err4)
`endif
  );

  mux_nb_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err (sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    for (int k = 0; k < 4; k++) bus.data_in[k*32 +: 32] = 32'h1000_0000 + k;
    bus.sel       = '0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus3.data_in  = {32'hCC, 32'hBB, 32'hAA};
    bus3.sel      = '0;
    bus3.in_valid = 1'b0;
    bus3.out_ready = 1'b1;

    // Reset with in_valid asserted: nothing may be accepted.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_beat_cnt",  64'(bus.beat_cnt),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_sel",   64'(bus.out_sel),   64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_no_beat", 64'(bus.out_valid), 64'd0);

    // Streaming four beats, one per clock.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sel      = i[1:0];
      bus.in_valid = 1'b1;
      tick();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_data",  64'(bus.out_data),  64'h1000_0000 + 64'(i));
      check("stream_sel",   64'(bus.out_sel),   64'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(bus.out_valid), 64'd0);
    check("stream_cnt",     64'(bus.beat_cnt),  64'd4);

    // Backpressure: A(sel=1) then B(sel=2) fill main and skid.
    bus.out_ready = 1'b0;
    bus.sel       = 2'd1;
    bus.in_valid  = 1'b1;
    tick();
    check("bp_a_data",  64'(bus.out_data), 64'h1000_0001);
    check("bp_a_ready", 64'(bus.in_ready), 64'd1);
    bus.sel = 2'd2;
    tick();
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold_data",  64'(bus.out_data), 64'h1000_0001);
    check("bp_hold_sel",   64'(bus.out_sel),  64'd1);
    bus.in_valid = 1'b0;
    bus.sel      = 2'd3;
    bus.data_in[32 +: 32] = 32'hDEAD_BEEF;
    tick();
    check("bp_stable_data", 64'(bus.out_data), 64'h1000_0001);
    check("bp_stable_sel",  64'(bus.out_sel),  64'd1);
    bus.data_in[32 +: 32] = 32'h1000_0001;
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_data",  64'(bus.out_data),  64'h1000_0002);
    check("bp_b_sel",   64'(bus.out_sel),   64'd2);
    check("bp_b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_b_ready", 64'(bus.in_ready),  64'd1);
    tick();
    check("bp_drained", 64'(bus.out_valid), 64'd0);
    check("bp_cnt",     64'(bus.beat_cnt),  64'd6);

    // Simultaneous in/out transfers for 8 clocks.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.sel      = i[1:0];
      bus.in_valid = 1'b1;
      tick();
      check("sim_data",  64'(bus.out_data), 64'h1000_0000 + 64'(i % 4));
      check("sim_sel",   64'(bus.out_sel),  64'(i % 4));
      check("sim_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sim_drained", 64'(bus.out_valid), 64'd0);
    check("sim_cnt",     64'(bus.beat_cnt),  64'd14);

    // Reset while FULL discards both entries.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd3;
    tick();
    bus.sel = 2'd0;
    tick();
    check("mid_full", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    check("mid_rst_cnt",   64'(bus.beat_cnt),  64'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd2;
    tick();
    check("mid_first_data", 64'(bus.out_data), 64'h1000_0002);
    check("mid_first_sel",  64'(bus.out_sel),  64'd2);
    bus.in_valid = 1'b0;
    tick();
    check("mid_drained", 64'(bus.out_valid), 64'd0);
    check("mid_cnt",     64'(bus.beat_cnt),  64'd1);

    // Out-of-range select on the 3-lane instance.
    bus3.sel      = 2'd3;
    bus3.in_valid = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
`ifdef MUX_SEL_CHECK_EN
    check("oor_sel_err", 64'(sel_err3),       64'd1);
    check("oor_dropped", 64'(bus3.out_valid), 64'd0);
    check("oor_cnt",     64'(bus3.beat_cnt),  64'd0);
`else
    check("oor_valid", 64'(bus3.out_valid), 64'd1);
    check("oor_data",  64'(bus3.out_data),  64'hAA);
    check("oor_sel",   64'(bus3.out_sel),   64'd3);
`endif
    bus3.sel      = 2'd2;
    bus3.in_valid = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    check("inr_data", 64'(bus3.out_data), 64'hCC);
    check("inr_sel",  64'(bus3.out_sel),  64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
